cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Common Data Bus arbiter and driver for the Tomasulo core. It collects `cdb_request` plus the pre-formatted `cdb_out` payload from every functional unit (ALU, MEM, MUL, DIV, JUMP). Each cycle it picks one requester round-robin and broadcasts that payload as a registered `cdb` word with the on bit set. Reservation stations and functional units observe the broadcast on the falling edge, so each winner sees "result taken" half a cycle after the grant.

## Interface
- `N_FU`, 5: number of functional-unit requesters. Index 0 has the highest initial priority.
- `PAY_W`, 38: payload width per FU, equal to `NUM_CDBBITS-1`. Layout is {FU tag, RS one-hot[2:0], data[31:0]}.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-low. Reset is applied at the rising edge of `clk` while `rst`=0.
- `flush`  input  1  synchronous squash. While `flush`=1, no grant is issued and `cdb` is cleared.
- `req`  input  N_FU  per-FU `cdb_request`. The FU holds it high until it samples its own tag on `cdb`.
- `pay`  input  N_FU*PAY_W  packed per-FU `cdb_out`. FU i occupies `pay[i*PAY_W +: PAY_W]`.
- `cdb`  output  PAY_W+1  registered bus {on, payload}. The on bit is the MSB (`CDB_ON_FIELD`).
- `grant`  output  N_FU  registered one-hot copy of the FU currently driving `cdb`; all zeros when idle.
- `bcast_cnt`  output  32  count of broadcast cycles; wraps modulo 2^32.
- `starve`  output  N_FU  per-FU flag. Bit i is 1 when FU i has waited at least 2*N_FU consecutive cycles without a grant.

## Operation
- State:
  - `ptr`: round-robin pointer holding an index in [0, N_FU-1].
  - `cdb` register and `grant` register.
  - `bcast_cnt`.
  - `wait_cnt[i]`: a 4-bit saturating counter per FU.
- Arbitration (combinational on the current `req`):
  - Search indices ptr, ptr+1, …, ptr+N_FU-1, all modulo N_FU.
  - The first index with its `req` bit set wins.
  - With no requests there is no winner.
- On a rising edge with `rst`=1 and `flush`=0:
  - If there is a winner w:
    - `cdb` ← {1'b1, `pay` slice w}.
    - `grant` ← one-hot(w).
    - `ptr` ← (w+1) mod N_FU.
    - `bcast_cnt` ← `bcast_cnt`+1.
  - If there is no winner:
    - `cdb` ← all zeros.
    - `grant` ← 0.
    - `ptr` is unchanged.
- The payload passes through unmodified. The arbiter never rewrites the tag, RS, or data fields.
- `wait_cnt[i]`:
  - Cleared when FU i is granted, or when `req[i]`=0.
  - Otherwise increments, saturating at 15.
  - `starve[i]` = (`wait_cnt[i]` ≥ 2*N_FU).
- `flush`=1 at a rising edge:
  - `cdb`, `grant`, and all `wait_cnt` are cleared.
  - `ptr` and `bcast_cnt` are held.
  - Pending requests stay pending and compete after `flush` deasserts.
- Reset (`rst`=0 at a rising edge): `cdb`=0, `grant`=0, `ptr`=0, `bcast_cnt`=0, all `wait_cnt`=0, `starve`=0. Reset takes priority over `flush`.

## Timing
- Sampling and drive:
  - `req` and `pay` are sampled at rising edge t.
  - `cdb` is valid from t until t+1.
  - FUs and reservation stations see the broadcast at the negedge inside that cycle.
- Handshake:
  - The granted FU drops `req` (or presents its next result) at that negedge.
  - The FU is therefore re-evaluated at t+1 with updated inputs.
  - Back-to-back grants to different FUs are legal every cycle.
  - A grant to the same FU in consecutive cycles happens only if that FU re-requests with a new payload.
- Latency: 1 cycle from `req` rising (sampled at an edge) to on=1, provided no other requester wins. Worst case under full load is N_FU cycles.
- The `pay` slice must be stable at the sampling edge. Changes between edges are ignored.
- `cdb` is held no longer than one cycle. An on=1 word never persists without a fresh grant.
- If a request arrives together with `flush`, it is not granted that edge.
- If `rst` falls mid-broadcast, `cdb` is cleared at the next edge and the broadcast is lost. This is acceptable because the FUs reset together with the arbiter.

## Test plan
- Reset, then idle with `req`=0 for 5 cycles → `cdb`=0, `grant`=0, `bcast_cnt`=0, `starve`=0.
- FU0 (ALU) requests with data 0x0000_0007, RS one-hot 100, and drops `req` at the next negedge → exactly one cycle of on=1 carrying that payload. Then `grant`=00001, `bcast_cnt`=1, `ptr`=1.
- FU0 and FU2 request in the same cycle and each holds until granted → FU0 is granted at edge t and FU2 at edge t+1. `ptr` ends at 3 and `bcast_cnt`=2.
- All 5 FUs request continuously, each re-requesting immediately → grant order 0,1,2,3,4,0,… and no `starve` bit ever rises.
- Force `req[3]`=1 while `flush` is held high for 12 cycles → `cdb` stays 0 and `starve[3]` stays 0. After `flush` drops, FU3 is granted on the next edge.
- Assert `rst`=0 for one edge while FU1 is driving `cdb` → at that edge `cdb`=0, `grant`=0, `ptr`=0, `bcast_cnt`=0. Normal arbitration resumes on the following edge.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Common Data Bus bundle between the functional units and the CDB arbiter.
// The FU side (master) drives requests and payloads; the arbiter (slave) drives the bus.
interface cdb_arbiter_if #(
    parameter int N_FU  = 5,
    parameter int PAY_W = 38
);
    logic [N_FU-1:0]       req;
    logic [N_FU*PAY_W-1:0] pay;
    logic [PAY_W:0]        cdb;
    logic [N_FU-1:0]       grant;
    logic [31:0]           bcast_cnt;
    logic [N_FU-1:0]       starve;

    modport master (output req, pay, input cdb, grant, bcast_cnt, starve);
    modport slave  (input req, pay, output cdb, grant, bcast_cnt, starve);
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter: picks one FU per cycle and broadcasts
// its payload as a registered {on, payload} word, with per-FU starvation flags.
module cdb_arbiter #(
    parameter int N_FU  = 5,
    parameter int PAY_W = 38
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    cdb_arbiter_if.slave bus
);
    localparam int         PTR_W     = (N_FU > 1) ? $clog2(N_FU) : 1;
    localparam logic [3:0] STARVE_TH = 4'(2 * N_FU);

    logic [PTR_W-1:0] ptr_r, ptr_nxt_s, win_s;
    logic             found_s;
    logic [PAY_W:0]   cdb_r, cdb_nxt_s;
    logic [N_FU-1:0]  grant_r, grant_nxt_s;
    logic [N_FU-1:0]  starve_r, starve_nxt_s;
    logic [31:0]      bcast_r, bcast_nxt_s;
    logic [3:0]       wait_r     [N_FU];
    logic [3:0]       wait_nxt_s [N_FU];

    // ptr + k never exceeds 2*N_FU-2, so one conditional subtract wraps it
    function automatic int wrap_idx(input int p, input int k);
        return ((p + k) >= N_FU) ? (p + k - N_FU) : (p + k);
    endfunction

    // Round-robin search starting at ptr; first requester wins
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        for (int k = 0; k < N_FU; k++) begin
            if (!found_s && bus.req[wrap_idx(int'(ptr_r), k)]) begin
                found_s = 1'b1;
                win_s   = PTR_W'(wrap_idx(int'(ptr_r), k));
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state for bus, grant, pointer and broadcast counter
    always_comb begin
        cdb_nxt_s   = '0;
        grant_nxt_s = '0;
        ptr_nxt_s   = ptr_r;
        bcast_nxt_s = bcast_r;
        if (flush) begin
            cdb_nxt_s   = '0;
            grant_nxt_s = '0;
        end else if (found_s) begin
            cdb_nxt_s   = {1'b1, bus.pay[int'(win_s)*PAY_W +: PAY_W]};
            grant_nxt_s = {{(N_FU-1){1'b0}}, 1'b1} << win_s;
            ptr_nxt_s   = (win_s == PTR_W'(N_FU - 1)) ? '0 : win_s + PTR_W'(1);
            bcast_nxt_s = bcast_r + 32'd1;
        end else begin
            cdb_nxt_s   = '0;
            grant_nxt_s = '0;
        end
    end

    // Per-FU wait counters: cleared on grant, idle or flush; otherwise saturate at 15
    always_comb begin
        for (int i = 0; i < N_FU; i++) begin
            wait_nxt_s[i] = 4'd0;
            if (flush || !bus.req[i]) begin
                wait_nxt_s[i] = 4'd0;
            end else if (found_s && (win_s == PTR_W'(i))) begin
                wait_nxt_s[i] = 4'd0;
            end else if (wait_r[i] == 4'd15) begin
                wait_nxt_s[i] = 4'd15;
            end else begin
                wait_nxt_s[i] = wait_r[i] + 4'd1;
            end
            starve_nxt_s[i] = (wait_nxt_s[i] >= STARVE_TH);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cdb_r    <= '0;
            grant_r  <= '0;
            ptr_r    <= '0;
            bcast_r  <= 32'd0;
            starve_r <= '0;
            for (int i = 0; i < N_FU; i++) begin
                wait_r[i] <= 4'd0;
            end
        end else begin
            cdb_r    <= cdb_nxt_s;
            grant_r  <= grant_nxt_s;
            ptr_r    <= ptr_nxt_s;
            bcast_r  <= bcast_nxt_s;
            starve_r <= starve_nxt_s;
            for (int i = 0; i < N_FU; i++) begin
                wait_r[i] <= wait_nxt_s[i];
            end
        end
    end

    assign bus.cdb       = cdb_r;
    assign bus.grant     = grant_r;
    assign bus.bcast_cnt = bcast_r;
    assign bus.starve    = starve_r;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed stimulus pushes expected broadcasts,
// a monitor pops and compares every on=1 word the arbiter presents.
module tb_cdb_arbiter;
    localparam int N_FU  = 5;
    localparam int PAY_W = 38;

    typedef struct packed {
        logic [PAY_W:0]  cdb;
        logic [N_FU-1:0] grant;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;
    exp_t exp_q[$];
    int   n_pass;
    int   n_total;

    cdb_arbiter_if #(.N_FU(N_FU), .PAY_W(PAY_W)) bus ();

    cdb_arbiter #(.N_FU(N_FU), .PAY_W(PAY_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
        n_total++;
        if (act === req_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req_v);
        end
    endtask

    function automatic logic [PAY_W-1:0] mk(input int fu, input logic [2:0] rs, input logic [31:0] d);
        return {3'(fu), rs, d};
    endfunction

    // Load FU slot and queue the broadcast it is expected to produce
    task automatic put(input int fu, input logic [PAY_W-1:0] p, input bit expect_grant);
        exp_t e;
        bus.pay[fu*PAY_W +: PAY_W] = p;
        if (expect_grant) begin
            e.cdb   = {1'b1, p};
            e.grant = 5'b00001 << fu;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: every on=1 word must match the head of the scoreboard
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (bus.cdb[PAY_W] === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bcast", 64'(bus.cdb), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("cdb_word", 64'(bus.cdb), 64'(e.cdb));
                chk("grant", 64'(bus.grant), 64'(e.grant));
            end
        end
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        flush   = 1'b0;
        bus.req = '0;
        bus.pay = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // idle after reset
        repeat (5) @(negedge clk);
        chk("idle_cdb", 64'(bus.cdb), 64'd0);
        chk("idle_grant", 64'(bus.grant), 64'd0);
        chk("idle_bcast", 64'(bus.bcast_cnt), 64'd0);
        chk("idle_starve", 64'(bus.starve), 64'd0);

        // single ALU result, one cycle on the bus
        put(0, mk(0, 3'b100, 32'h0000_0007), 1'b1);
        bus.req = 5'b00001;
        @(negedge clk);
        bus.req = 5'b00000;
        @(negedge clk);
        chk("single_cdb_cleared", 64'(bus.cdb), 64'd0);
        chk("single_grant_cleared", 64'(bus.grant), 64'd0);
        chk("single_bcast", 64'(bus.bcast_cnt), 64'd1);

        // FU0 and FU2 together from ptr=0, then FU1+FU3 from ptr=3
        do_reset();
        put(0, mk(0, 3'b001, 32'hAAAA_0000), 1'b1);
        put(2, mk(2, 3'b010, 32'hCCCC_2222), 1'b1);
        bus.req = 5'b00101;
        @(negedge clk);
        bus.req = 5'b00100;
        @(negedge clk);
        bus.req = 5'b00000;
        @(negedge clk);
        chk("pair_bcast", 64'(bus.bcast_cnt), 64'd2);
        put(3, mk(3, 3'b100, 32'h3333_3333), 1'b1);
        put(1, mk(1, 3'b001, 32'h1111_1111), 1'b1);
        bus.req = 5'b01010;
        @(negedge clk);
        bus.req = 5'b00010;
        @(negedge clk);
        bus.req = 5'b00000;
        @(negedge clk);
        chk("ptr3_bcast", 64'(bus.bcast_cnt), 64'd4);

        // full load, each FU re-requests with a fresh payload every cycle
        do_reset();
        for (int k = 0; k < 15; k++) begin
            for (int f = 0; f < N_FU; f++) begin
                put(f, mk(f, 3'b001, 32'(k * 16 + f)), (f == (k % N_FU)));
            end
            bus.req = 5'b11111;
            @(negedge clk);
            chk("load_starve", 64'(bus.starve), 64'd0);
        end
        bus.req = 5'b00000;
        @(negedge clk);
        chk("load_bcast", 64'(bus.bcast_cnt), 64'd15);

        // request held under flush is squashed, then granted right after
        flush = 1'b1;
        put(3, mk(3, 3'b010, 32'hDEAD_BEEF), 1'b0);
        bus.req = 5'b01000;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("flush_cdb", 64'(bus.cdb), 64'd0);
            chk("flush_starve3", 64'(bus.starve[3]), 64'd0);
        end
        chk("flush_bcast_held", 64'(bus.bcast_cnt), 64'd15);
        flush = 1'b0;
        put(3, mk(3, 3'b010, 32'hDEAD_BEEF), 1'b1);
        @(negedge clk);
        bus.req = 5'b00000;
        @(negedge clk);
        chk("post_flush_bcast", 64'(bus.bcast_cnt), 64'd16);

        // reset while FU1 drives the bus
        put(1, mk(1, 3'b100, 32'h0101_0101), 1'b1);
        bus.req = 5'b00010;
        @(negedge clk);
        rst     = 1'b0;
        bus.req = 5'b00000;
        @(negedge clk);
        chk("rst_cdb", 64'(bus.cdb), 64'd0);
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_bcast", 64'(bus.bcast_cnt), 64'd0);
        rst = 1'b1;
        put(0, mk(0, 3'b001, 32'h0000_00F0), 1'b1);
        put(1, mk(1, 3'b010, 32'h0000_00F1), 1'b1);
        bus.req = 5'b00011;
        @(negedge clk);
        bus.req = 5'b00010;
        @(negedge clk);
        bus.req = 5'b00000;
        repeat (3) @(negedge clk);
        chk("resume_bcast", 64'(bus.bcast_cnt), 64'd2);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
